store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE (32); width of addresses and data.
REQ-002 Parameter N_ENTRIES, default 4; buffer depth, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 push_valid  input  1  a committed store is presented for insertion.
REQ-006 push_addr  input  WORD_SIZE  byte address of the store (ALU aluOut for OPCODE_STORE).
REQ-007 push_data  input  WORD_SIZE  store data; for byte stores only bits [7:0] are meaningful.
REQ-008 push_byte  input  1  1 = byte store (SB), 0 = word store (SW).
REQ-009 full  output  1  count == N_ENTRIES; upstream shall stall its store.
REQ-010 empty  output  1  count == 0.
REQ-011 count  output  $clog2(N_ENTRIES)+1  number of valid entries.
REQ-012 lookup_addr  input  WORD_SIZE  load address (ALU aluOut for OPCODE_LOAD).
REQ-013 lookup_byte  input  1  1 = byte load, 0 = word load.
REQ-014 lookup_hit  output  1  load data is forwarded from the buffer.
REQ-015 lookup_data  output  WORD_SIZE  forwarded data, valid when lookup_hit = 1.
REQ-016 lookup_conflict  output  1  a partial overlap exists; the load shall stall.
REQ-017 drain_valid  output  1  head entry is offered to the data cache.
REQ-018 drain_addr / drain_data / drain_byte  output  WORD_SIZE/WORD_SIZE/1  head entry contents.
REQ-019 drain_ready  input  1  data cache accepts the head entry this cycle.

Function
REQ-020 Circular FIFO with head and tail pointers of $clog2(N_ENTRIES) bits each; both pointers wrap from N_ENTRIES-1 to 0.
REQ-021 Push: when push_valid=1 and full=0, write the entry at tail, advance tail, and increment count at the next edge.
REQ-022 Push while full=1 is ignored with no state change; full is derived from registered count, so a same-cycle pop does not unblock the push.
REQ-023 drain_valid = !empty; drain_* outputs show the head entry combinationally from the registers.
REQ-024 Pop: when drain_valid=1 and drain_ready=1, advance head and decrement count; drain_ready while empty is ignored.
REQ-025 Simultaneous accepted push and pop leave count unchanged while both pointers advance.
REQ-026 Stores drain strictly in program (insertion) order.
REQ-027 Forwarding is combinational in the same cycle: compare lookup_addr[WORD_SIZE-1:2] against every valid entry and select the youngest matching entry.
REQ-028 Youngest match is a word store: lookup_hit=1; lookup_data = the entry data for a word load, or the zero-extended byte at lookup_addr[1:0] for a byte load.
REQ-029 Youngest match is a byte store, lookup is a byte load, and the full addresses are equal: lookup_hit=1, lookup_data = {zeros, data[7:0]}.
REQ-030 Any other youngest-match case (byte store versus word load, or byte store to a different byte lane): lookup_hit=0, lookup_conflict=1.
REQ-031 No match: lookup_hit=0, lookup_conflict=0, lookup_data=0.
REQ-032 Lookup shall only see registered entries; a push in the same cycle is not visible until the next cycle.
REQ-033 An entry being popped in the current cycle still participates in lookup during that cycle.

Reset
REQ-034 rst_n=0 immediately clears head, tail, count and all entry valid state; outputs become full=0, empty=1, count=0, drain_valid=0, lookup_hit=0, lookup_conflict=0.
REQ-035 Reset asserted mid-drain discards all entries with no further drain_valid; entry data registers are not reset.

Structure
REQ-036 Put the entry struct (addr, data, byte) and the N_ENTRIES default in the shared defines/package next to `WORD_SIZE and the opcodes.
REQ-037 Implement the youngest-match search as one sub-module, sb_match_select: a combinational priority selector ordered from tail-1 back to head.

Verification
REQ-038 Reset, push SW 0x100/0xDEADBEEF, drain_ready=0 -> count=1, drain_valid=1, drain_addr=0x100.
REQ-039 Push 4 stores with drain_ready=0 -> full=1; a 5th push is ignored; after 4 pops, order is preserved and empty=1.
REQ-040 Push SW 0x200/0x11223344, then SB 0x201/0xAA; LW 0x200 -> conflict=1; LB 0x201 -> hit, data=0xAA; LB 0x202 -> conflict=1.
REQ-041 Push SW 0x300/0x01, then SW 0x300/0x02; LW 0x300 -> hit, data=0x02 (youngest entry wins).
REQ-042 Full buffer with push and drain_ready in the same cycle -> push rejected, count=3; 8 push/pop cycles show correct pointer wrap-around.
REQ-043 Assert rst_n=0 with 3 entries during a drain handshake -> empty=1 asynchronously and no further drain.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: word size, default depth, opcodes
// and the buffered-store entry layout.
package store_buffer_pkg;

    localparam int SB_WORD_SIZE = 32;
    localparam int SB_N_ENTRIES = 4;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    typedef struct packed {
        logic [SB_WORD_SIZE-1:0] addr;
        logic [SB_WORD_SIZE-1:0] data;
        logic                    is_byte;
    } sb_entry_t;

endpackage

// File: rtl/sb_match_select.sv
// Youngest-match priority selector: scans entries from tail-1 back towards
// head and reports the first (youngest) entry whose match bit is set.
module sb_match_select #(
    parameter int N_ENTRIES = 4
) (
    input  logic [N_ENTRIES-1:0]         match,
    input  logic [$clog2(N_ENTRIES)-1:0] tail,
    output logic                         found,
    output logic [$clog2(N_ENTRIES)-1:0] sel
);

    localparam int PW = $clog2(N_ENTRIES);

    // Only valid entries can match, and valid entries occupy head..tail-1,
    // so walking backwards from tail-1 visits them youngest first.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_ENTRIES; k++) begin
            if (!found && match[tail - PW'(k + 1)]) begin
                found = 1'b1;
                sel   = tail - PW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: in-order FIFO of committed stores drained to the data cache,
// with same-cycle store-to-load forwarding and partial-overlap detection.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int WORD_SIZE = SB_WORD_SIZE,
    parameter int N_ENTRIES = SB_N_ENTRIES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_valid,
    input  logic [WORD_SIZE-1:0]         push_addr,
    input  logic [WORD_SIZE-1:0]         push_data,
    input  logic                         push_byte,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(N_ENTRIES):0]   count,
    input  logic [WORD_SIZE-1:0]         lookup_addr,
    input  logic                         lookup_byte,
    output logic                         lookup_hit,
    output logic [WORD_SIZE-1:0]         lookup_data,
    output logic                         lookup_conflict,
    output logic                         drain_valid,
    output logic [WORD_SIZE-1:0]         drain_addr,
    output logic [WORD_SIZE-1:0]         drain_data,
    output logic                         drain_byte,
    input  logic                         drain_ready
);

    localparam int PW = $clog2(N_ENTRIES);
    localparam int CW = PW + 1;

    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [N_ENTRIES-1:0] valid;
    logic [WORD_SIZE-1:0] mem_addr [N_ENTRIES];
    logic [WORD_SIZE-1:0] mem_data [N_ENTRIES];
    logic                 mem_byte [N_ENTRIES];

    logic push_ok;
    logic pop_ok;

    // Handshakes: a push is accepted on a rising edge when push_valid=1 and
    // full=0; the head entry is retired when drain_valid=1 and drain_ready=1.
    // Both conditions use registered state only, so a pop never frees a slot
    // for a push in the same cycle.
    assign full    = (count == CW'(N_ENTRIES));
    assign empty   = (count == '0);
    assign push_ok = push_valid && !full;
    assign pop_ok  = drain_valid && drain_ready;

    assign drain_valid = !empty;
    assign drain_addr  = mem_addr[head];
    assign drain_data  = mem_data[head];
    assign drain_byte  = mem_byte[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop_ok) begin
                head        <= head + PW'(1);
                valid[head] <= 1'b0;
            end
            if (push_ok) begin
                tail        <= tail + PW'(1);
                valid[tail] <= 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity alone decides visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[tail] <= push_addr;
            mem_data[tail] <= push_data;
            mem_byte[tail] <= push_byte;
        end
    end

    logic [N_ENTRIES-1:0] match;
    logic                 any_match;
    logic [PW-1:0]        sel;

    always_comb begin
        match = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            match[i] = valid[i] &&
                       (mem_addr[i][WORD_SIZE-1:2] == lookup_addr[WORD_SIZE-1:2]);
        end
    end

    sb_match_select #(
        .N_ENTRIES (N_ENTRIES)
    ) u_match_select (
        .match (match),
        .tail  (tail),
        .found (any_match),
        .sel   (sel)
    );

    logic [WORD_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_data;
    logic                 sel_byte;
    logic [7:0]           lane;

    assign sel_addr = mem_addr[sel];
    assign sel_data = mem_data[sel];
    assign sel_byte = mem_byte[sel];
    assign lane     = 8'(sel_data >> {lookup_addr[1:0], 3'b000});

    // A byte store can only satisfy a byte load to exactly the same address;
    // every other overlap with a byte store forces the load to wait.
    always_comb begin
        lookup_hit      = 1'b0;
        lookup_conflict = 1'b0;
        lookup_data     = '0;
        if (any_match) begin
            if (!sel_byte) begin
                lookup_hit  = 1'b1;
                lookup_data = lookup_byte ? {{(WORD_SIZE-8){1'b0}}, lane} : sel_data;
            end else if (lookup_byte && (sel_addr == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = {{(WORD_SIZE-8){1'b0}}, sel_data[7:0]};
            end else begin
                lookup_conflict = 1'b1;
            end
        end
    end

endmodule
